alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
- Initiator-side front end for the 16-bit combinational ALU (ports A, B, f_Sel, Out).
- Accepts operation commands over a valid/ready interface and queues them in a small FIFO.
- Drives registered operands and opcode into the ALU, captures the result, and returns it with a tag and status flags over a valid/ready response interface.
- Sits between the control sequencer and the ALU datapath.

Parameters:
- DATA_W, 16, operand/result width (must match the ALU).
- DEPTH, 4, command FIFO depth; power of two, at least 2.
- TAG_W, 4, width of the command tag returned with the response.

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clk edge
- cmd_op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
- cmd_a  in  DATA_W  operand A
- cmd_b  in  DATA_W  operand B
- cmd_tag  in  TAG_W  command tag, echoed in the response
- alu_a  out  DATA_W  to ALU A
- alu_b  out  DATA_W  to ALU B
- alu_fsel  out  3  to ALU f_Sel
- alu_out  in  DATA_W  from ALU Out
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a clk edge
- rsp_data  out  DATA_W  captured result
- rsp_tag  out  TAG_W  tag of the originating command
- rsp_zero  out  1  rsp_data == 0
- rsp_illegal  out  1  opcode was 101/110/111
- busy  out  1  FIFO non-empty, or state ISSUE, or rsp_valid
- err_mismatch  out  1  sticky ALU check error (see Optional Feature)

Behaviour:
- Reset: asynchronous, active-low; clears FIFO and state.
  - State = IDLE; all registered outputs = 0 (alu_a, alu_b, alu_fsel, rsp_*, err_mismatch).
  - cmd_ready = 1 while in reset and after reset.
  - Asserting reset mid-operation discards all queued commands and any pending response; no partial response is emitted.
- cmd_ready = !fifo_full, combinational from the count only. A push while full is never accepted, even if a pop happens in the same cycle.
- FIFO pop decisions use the registered count only: no bypass. A command pushed into an empty FIFO is popped at the next edge at the earliest.
- FSM has two states: IDLE and ISSUE.
  - IDLE: alu_* hold their last values. If the FIFO is non-empty, pop the head into the operand registers (alu_a, alu_b, alu_fsel, plus internal tag/illegal) and go to ISSUE.
  - ISSUE: the ALU output is valid this cycle. Define slot_free = !rsp_valid || rsp_ready.
    - If slot_free, at the edge: capture rsp_data = alu_out, rsp_tag, rsp_zero, rsp_illegal; set rsp_valid = 1.
      - Then, if the FIFO is non-empty, pop the next head and stay in ISSUE.
      - Otherwise go to IDLE.
    - If !slot_free: stall. Operands are held stable; no pop.
- rsp_valid clears on handshake unless a new capture occurs at the same edge.
- Response outputs are stable while rsp_valid && !rsp_ready.
- Latency: a command accepted at edge N with the FIFO empty reaches ISSUE at edge N+1, and rsp_valid rises at edge N+2.
- Throughput: one response per cycle when rsp_ready is held high.
- Capacity: DEPTH + 2 outstanding commands (FIFO + ISSUE + response register).
- Illegal opcodes are forwarded to the ALU unchanged. The ALU returns 0, so rsp_data = 0, rsp_illegal = 1 and rsp_zero = 1.
- Arithmetic wraps modulo 2^DATA_W. No carry or overflow is reported.
- Ordering: responses are returned strictly in command order.

Optional Feature:
- Macro: ALU_CHECK_EN.
- Defined: an internal golden model computes the expected result from the operand registers.
  - On each capture where alu_out differs from the golden result, err_mismatch is set.
  - err_mismatch is sticky and cleared only by reset.
- Not defined: no checker logic; err_mismatch is tied to 0 and the port remains.

Decomposition:
- Package alu_issuer_pkg contains:
  - alu_op_e enum (ADD=3'b000, SUB, AND, OR, XOR=3'b100)
  - DATA_W_DEF = 16
  - issuer_state_e {IDLE, ISSUE}
  - alu_cmd_t struct {op, a, b, tag}
  - is_legal_op() function
- One sub-module: sync_fifo, parameterised on width and DEPTH, with push/pop/full/empty/count.
- The golden-model function lives in the package, guarded by ALU_CHECK_EN.

Test Plan:
- ADD A=0xFFFF, B=0x0001, tag 3, rsp_ready=1 -> rsp_valid 2 cycles after accept; rsp_data=0x0000, rsp_zero=1, rsp_tag=3, rsp_illegal=0.
- SUB A=0x0005, B=0x0007, then XOR A=0xA5A5, B=0xFFFF, back-to-back -> responses 0xFFFE then 0x5A5A in order, on consecutive cycles.
- Opcode 3'b110, A=0x1234, B=0x1 -> rsp_data=0x0000, rsp_illegal=1, rsp_zero=1.
- Hold rsp_ready=0 and issue 8 commands -> cmd_ready drops after 6 accepted (DEPTH+2) and the first response is held stable. Release rsp_ready -> all 6 drain in order, then the remaining 2 are accepted.
- Pull rst_n low while 3 commands are queued and a response is pending -> rsp_valid=0, busy=0, cmd_ready=1, alu_* = 0 immediately; no stale response after release.
- ALU_CHECK_EN defined, ALU model forced to return AND result for an OR command (A=0x00F0, B=0x0F00) -> err_mismatch=1 and stays set until reset.

Source files
------------

// File: rtl/alu_issuer_pkg.sv
`default_nettype none
// ============================================================================
// alu_issuer_pkg : shared types, opcodes and helpers for alu_cmd_issuer
// Optional golden model is compiled in when ALU_CHECK_EN is defined.
// Revision: 1.0
// ============================================================================
package alu_issuer_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int TAG_W_DEF  = 4;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        XOR = 3'b100
    } alu_op_e;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } issuer_state_e;

    // Opcode is kept as raw bits so illegal codes travel to the ALU unchanged.
    typedef struct packed {
        logic [2:0]            op;
        logic [DATA_W_DEF-1:0] a;
        logic [DATA_W_DEF-1:0] b;
        logic [TAG_W_DEF-1:0]  tag;
    } alu_cmd_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= 3'b100);
    endfunction

`ifdef ALU_CHECK_EN
    function automatic logic [DATA_W_DEF-1:0] alu_golden(
        input logic [2:0]            op,
        input logic [DATA_W_DEF-1:0] a,
        input logic [DATA_W_DEF-1:0] b
    );
        case (alu_op_e'(op))
            ADD:     return a + b;
            SUB:     return a - b;
            AND:     return a & b;
            OR:      return a | b;
            XOR:     return a ^ b;
            default: return '0;
        endcase
    endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/alu_cmd_issuer_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO, power-of-two DEPTH, registered count
// Revision: 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Flags depend on the registered count only, so a same-cycle pop never frees a slot.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// alu_cmd_issuer : queues ALU commands, drives registered operands, returns
// tagged results. Define ALU_CHECK_EN to enable the sticky golden-model check.
// Revision: 1.0
// ============================================================================
module alu_cmd_issuer
    import alu_issuer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_fsel,
    input  logic [DATA_W-1:0] alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_zero,
    output logic              rsp_illegal,
    output logic              busy,
    output logic              err_mismatch
);

    localparam int CMD_W = $bits(alu_cmd_t);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    alu_cmd_t          cmd_in;
    alu_cmd_t          fifo_head;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    issuer_state_e     state_q, state_d;
    logic              capture;
    logic              slot_free;

    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [2:0]        alu_fsel_q, alu_fsel_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              illegal_q, illegal_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_illegal_q, rsp_illegal_d;

    always_comb begin
        cmd_in     = '0;
        cmd_in.op  = cmd_op;
        cmd_in.a   = DATA_W_DEF'(cmd_a);
        cmd_in.b   = DATA_W_DEF'(cmd_b);
        cmd_in.tag = TAG_W_DEF'(cmd_tag);
    end

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && !fifo_full;

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (cmd_in),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The response register is free if empty or being drained this cycle.
    assign slot_free = !rsp_valid_q || rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (slot_free) begin
                    capture = 1'b1;
                    if (!fifo_empty) fifo_pop = 1'b1;
                    else             state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_fsel_d    = alu_fsel_q;
        tag_d         = tag_q;
        illegal_d     = illegal_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_illegal_d = rsp_illegal_q;
        if (fifo_pop) begin
            alu_a_d    = DATA_W'(fifo_head.a);
            alu_b_d    = DATA_W'(fifo_head.b);
            alu_fsel_d = fifo_head.op;
            tag_d      = TAG_W'(fifo_head.tag);
            illegal_d  = !is_legal_op(fifo_head.op);
        end
        if (capture) begin
            rsp_valid_d   = 1'b1;
            rsp_data_d    = alu_out;
            rsp_tag_d     = tag_q;
            rsp_zero_d    = (alu_out == '0);
            rsp_illegal_d = illegal_q;
        end else if (rsp_ready) begin
            rsp_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_fsel_q    <= '0;
            tag_q         <= '0;
            illegal_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_tag_q     <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_fsel_q    <= alu_fsel_d;
            tag_q         <= tag_d;
            illegal_q     <= illegal_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

`ifdef ALU_CHECK_EN
    logic              err_q, err_d;
    logic [DATA_W-1:0] golden;

    assign golden = DATA_W'(alu_golden(alu_fsel_q, DATA_W_DEF'(alu_a_q), DATA_W_DEF'(alu_b_q)));

    always_comb begin
        err_d = err_q;
        if (capture && (alu_out != golden)) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_mismatch = err_q;
`else
    assign err_mismatch = 1'b0;
`endif

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_fsel    = alu_fsel_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_illegal = rsp_illegal_q;
    assign busy        = (fifo_count != '0) || (state_q == ISSUE) || rsp_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// tb_alu_cmd_issuer : directed self-checking bench for alu_cmd_issuer
// Revision: 1.0
// ============================================================================
module tb_alu_cmd_issuer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic [3:0]  cmd_tag = '0;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_fsel;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        rsp_zero, rsp_illegal, busy, err_mismatch;
    logic        force_bad = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef ALU_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    // Behavioural ALU; force_bad makes OR return the AND result.
    always_comb begin
        case (alu_fsel)
            3'b000:  alu_out = alu_a + alu_b;
            3'b001:  alu_out = alu_a - alu_b;
            3'b010:  alu_out = alu_a & alu_b;
            3'b011:  alu_out = force_bad ? (alu_a & alu_b) : (alu_a | alu_b);
            3'b100:  alu_out = alu_a ^ alu_b;
            default: alu_out = '0;
        endcase
    end

    alu_cmd_issuer #(
        .DATA_W (16),
        .DEPTH  (4),
        .TAG_W  (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_tag      (cmd_tag),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_fsel     (alu_fsel),
        .alu_out      (alu_out),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_tag      (rsp_tag),
        .rsp_zero     (rsp_zero),
        .rsp_illegal  (rsp_illegal),
        .busy         (busy),
        .err_mismatch (err_mismatch)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered and left at a falling edge; returns one half-cycle after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tag);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drive(input int idx);
        cmd_valid = 1'b1;
        cmd_op    = 3'b000;
        cmd_a     = 16'h1000 + idx[15:0];
        cmd_b     = 16'h0010;
        cmd_tag   = idx[3:0];
    endtask

    task automatic expect_rsp(input string name, input logic [15:0] d, input logic [3:0] t,
                              input logic z, input logic il);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"},   rsp_valid,   1);
        check({name, "_data"},    rsp_data,    d);
        check({name, "_tag"},     rsp_tag,     t);
        check({name, "_zero"},    rsp_zero,    z);
        check({name, "_illegal"}, rsp_illegal, il);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc;
        int   nrsp;
        logic saw;
        logic take;

        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready,    1);
        check("rst_rsp_valid", rsp_valid,    0);
        check("rst_busy",      busy,         0);
        check("rst_alu_a",     alu_a,        0);
        check("rst_alu_fsel",  alu_fsel,     0);
        check("rst_rsp_data",  rsp_data,     0);
        check("rst_err",       err_mismatch, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD wrap-around, exact two-cycle latency
        send(3'b000, 16'hFFFF, 16'h0001, 4'd3);
        check("t1_valid_e0", rsp_valid, 0);
        check("t1_busy",     busy,      1);
        @(negedge clk);
        check("t1_valid_e1", rsp_valid, 0);
        check("t1_alu_a",    alu_a,     16'hFFFF);
        check("t1_alu_b",    alu_b,     16'h0001);
        @(negedge clk);
        check("t1_valid_e2", rsp_valid,   1);
        check("t1_data",     rsp_data,    16'h0000);
        check("t1_zero",     rsp_zero,    1);
        check("t1_tag",      rsp_tag,     3);
        check("t1_illegal",  rsp_illegal, 0);
        @(negedge clk);
        check("t1_drained",  rsp_valid,   0);
        check("t1_idle",     busy,        0);

        // Back-to-back SUB then XOR on consecutive cycles
        send(3'b001, 16'h0005, 16'h0007, 4'd1);
        send(3'b100, 16'hA5A5, 16'hFFFF, 4'd2);
        @(negedge clk);
        check("t2_r0_valid", rsp_valid, 1);
        check("t2_r0_data",  rsp_data,  16'hFFFE);
        check("t2_r0_tag",   rsp_tag,   1);
        @(negedge clk);
        check("t2_r1_valid", rsp_valid, 1);
        check("t2_r1_data",  rsp_data,  16'h5A5A);
        check("t2_r1_tag",   rsp_tag,   2);
        @(negedge clk);
        check("t2_drained",  rsp_valid, 0);

        // Illegal opcode forwarded unchanged
        send(3'b110, 16'h1234, 16'h0001, 4'd5);
        @(negedge clk);
        check("t3_fsel", alu_fsel, 3'b110);
        @(negedge clk);
        check("t3_valid",   rsp_valid,   1);
        check("t3_data",    rsp_data,    16'h0000);
        check("t3_illegal", rsp_illegal, 1);
        check("t3_zero",    rsp_zero,    1);
        check("t3_tag",     rsp_tag,     5);
        @(negedge clk);

        send(3'b010, 16'hF0F0, 16'h3C3C, 4'd7);
        expect_rsp("t_and", 16'h3030, 4'd7, 1'b0, 1'b0);
        send(3'b011, 16'h00F0, 16'h0F00, 4'd8);
        expect_rsp("t_or", 16'h0FF0, 4'd8, 1'b0, 1'b0);
        check("t_or_err", err_mismatch, 0);

        // Faulty ALU on an OR command
        force_bad = 1'b1;
        send(3'b011, 16'h00F0, 16'h0F00, 4'd9);
        expect_rsp("t_bad", 16'h0000, 4'd9, 1'b1, 1'b0);
        force_bad = 1'b0;
        check("t_bad_err", err_mismatch, EXP_ERR);
        send(3'b000, 16'h0001, 16'h0002, 4'd10);
        expect_rsp("t_sticky", 16'h0003, 4'd10, 1'b0, 1'b0);
        check("t_sticky_err", err_mismatch, EXP_ERR);

        // Capacity with response back-pressure
        rsp_ready = 1'b0;
        acc = 0;
        drive(0);
        for (int c = 0; c < 12; c++) begin
            saw = cmd_ready;
            @(negedge clk);
            if (saw) begin
                acc++;
                drive(acc);
            end
        end
        check("t4_accepted", acc,       6);
        check("t4_ready",    cmd_ready, 0);
        check("t4_valid",    rsp_valid, 1);
        check("t4_data",     rsp_data,  16'h1010);
        check("t4_tag",      rsp_tag,   0);
        repeat (3) @(negedge clk);
        check("t4_hold_data", rsp_data, 16'h1010);
        check("t4_hold_tag",  rsp_tag,  0);

        rsp_ready = 1'b1;
        nrsp = 0;
        for (int c = 0; c < 40 && nrsp < 8; c++) begin
            saw  = cmd_valid && cmd_ready;
            take = rsp_valid;
            if (take) begin
                check("t4_rsp_data", rsp_data, 16'h1010 + nrsp[15:0]);
                check("t4_rsp_tag",  rsp_tag,  nrsp[3:0]);
            end
            @(negedge clk);
            if (saw) begin
                acc++;
                if (acc < 8) drive(acc);
                else         cmd_valid = 1'b0;
            end
            if (take) nrsp++;
        end
        cmd_valid = 1'b0;
        check("t4_nrsp",    nrsp, 8);
        check("t4_acc_all", acc,  8);

        // Reset with queued commands and a pending response
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(3'b000, 16'(i), 16'h0000, 4'(i));
        repeat (2) @(negedge clk);
        check("t5_pre_busy",  busy,      1);
        check("t5_pre_valid", rsp_valid, 1);
        check("t5_pre_alu_a", alu_a,     1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid",     rsp_valid,    0);
        check("t5_rst_busy",      busy,         0);
        check("t5_rst_cmd_ready", cmd_ready,    1);
        check("t5_rst_alu_a",     alu_a,        0);
        check("t5_rst_alu_b",     alu_b,        0);
        check("t5_rst_alu_fsel",  alu_fsel,     0);
        check("t5_rst_err",       err_mismatch, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
        end
        check("t5_no_stale", saw,  0);
        check("t5_idle",     busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
